// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - fetch/data request ports and shared memory port of the bus arbiter
interface mem_bus_arbiter_if;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_data;

    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [63:0] d_rdata;

    logic        m_valid;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [63:0] m_rdata;

    // Arbiter view: takes requests from both stages, drives the memory port.
    modport master (
        input  i_valid, i_addr,
        output i_addr_ok, i_data_ok, i_data,
        input  d_valid, d_addr, d_size, d_strobe, d_wdata,
        output d_addr_ok, d_data_ok, d_rdata,
        output m_valid, m_addr, m_size, m_strobe, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    modport slave (
        output i_valid, i_addr,
        input  i_addr_ok, i_data_ok, i_data,
        output d_valid, d_addr, d_size, d_strobe, d_wdata,
        input  d_addr_ok, d_data_ok, d_rdata,
        input  m_valid, m_addr, m_size, m_strobe, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory port between instruction fetch and the memory stage
module mem_bus_arbiter #(
    parameter bit D_PRIORITY = 1'b1,
    parameter int MAX_STARVE = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_bus_arbiter_if.master bus
);
    localparam int          SW         = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
    localparam logic [2:0]  I_SIZE     = 3'd2;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t          state, state_nxt;
    logic            last_grant_d;
    logic [SW-1:0]   starve_cnt;
    logic            pick_d;
    logic [31:0]     i_word;

    always_comb begin
        pick_d = 1'b0;
        if (bus.d_valid && !bus.i_valid) begin
            pick_d = 1'b1;
        end else if (bus.d_valid && bus.i_valid) begin
            pick_d = D_PRIORITY ? (starve_cnt != STARVE_MAX) : !last_grant_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.i_valid || bus.d_valid) begin
                    state_nxt = pick_d ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                // The grant is held until the memory answers, even if the requester lets go.
                if (bus.m_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign i_word = bus.i_addr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];

    always_comb begin
        bus.m_valid   = 1'b0;
        bus.m_addr    = '0;
        bus.m_size    = '0;
        bus.m_strobe  = '0;
        bus.m_wdata   = '0;
        bus.i_addr_ok = 1'b0;
        bus.i_data_ok = 1'b0;
        bus.i_data    = '0;
        bus.d_addr_ok = 1'b0;
        bus.d_data_ok = 1'b0;
        bus.d_rdata   = '0;
        case (state)
            GRANT_I: begin
                bus.m_valid   = bus.i_valid;
                bus.m_addr    = bus.i_addr;
                bus.m_size    = I_SIZE;
                bus.i_addr_ok = bus.m_addr_ok;
                bus.i_data_ok = bus.m_data_ok;
                bus.i_data    = i_word;
            end
            GRANT_D: begin
                bus.m_valid   = bus.d_valid;
                bus.m_addr    = bus.d_addr;
                bus.m_size    = bus.d_size;
                bus.m_strobe  = bus.d_strobe;
                bus.m_wdata   = bus.d_wdata;
                bus.d_addr_ok = bus.m_addr_ok;
                bus.d_data_ok = bus.m_data_ok;
                bus.d_rdata   = bus.m_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            starve_cnt   <= '0;
        end else begin
            state <= state_nxt;
            // Starvation is counted per D grant that bypasses a waiting fetch.
            if (state == IDLE && state_nxt == GRANT_D) begin
                if (!bus.i_valid) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end else if (state == IDLE && state_nxt == GRANT_I) begin
                starve_cnt <= '0;
            end
            if (state != IDLE && bus.m_data_ok) begin
                last_grant_d <= (state == GRANT_D);
            end
        end
    end
endmodule
